fifo_push_arbiter: RTL

//  Shares the push port of one FIFO instance among N_REQ producers by round-robin arbitration.

---
 rtl/fifo_push_arbiter.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/fifo_push_arbiter.sv
// Round-robin push arbiter and occupancy tracker for a flagless FIFO instance.
// Optional producer lock (burst hold) is compiled in with `define FIFO_ARB_LOCK_EN.

module fifo_push_arbiter_lane #(
  parameter int IDX        = 0,
  parameter int PTR_W      = 2,
  parameter int FIFO_width = 4
) (
  input  logic                  req_i,
  input  logic                  allow_i,
  input  logic [PTR_W-1:0]      rr_ptr_i,
  input  logic                  gnt_i,
  input  logic [FIFO_width-1:0] data_i,
  output logic                  req_v_o,
  output logic                  hi_o,
  output logic [FIFO_width-1:0] data_o
);
  assign req_v_o = req_i & allow_i;
  // Lanes at or above the pointer win first; the rest only on wrap.
  assign hi_o    = req_v_o & (PTR_W'(IDX) >= rr_ptr_i);
  assign data_o  = gnt_i ? data_i : '0;
endmodule

module fifo_push_arbiter #(
  parameter int N_REQ      = 4,
  parameter int FIFO_depth = 8,
  parameter int FIFO_width = 4,
  parameter int LVL_W      = 4
) (
  input  logic                        clk,
  input  logic                        FIFO_reset,
  input  logic [N_REQ-1:0]            req,
  input  logic [N_REQ*FIFO_width-1:0] req_data,
`ifdef FIFO_ARB_LOCK_EN
  input  logic [N_REQ-1:0]            lock,
`endif
  output logic [N_REQ-1:0]            gnt,
  input  logic                        cons_pop,
  output logic                        cons_ack,
  input  logic                        flush,
  output logic                        fifo_push,
  output logic                        fifo_pop,
  output logic [FIFO_width-1:0]       fifo_data_in,
  output logic                        fifo_reset_n,
  output logic [LVL_W-1:0]            level,
  output logic                        full,
  output logic                        empty
);
  localparam int PTR_W = $clog2(N_REQ);

  logic [PTR_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic             full_q, full_d;
  logic             empty_q, empty_d;

  logic                                 allow;
  logic [N_REQ-1:0]                     req_v, hi;
  logic [N_REQ-1:0][FIFO_width-1:0]     lane_data;
  logic [PTR_W-1:0]                     gnt_idx;
  logic                                 gnt_any, hi_found, push, pop;
  logic [FIFO_width-1:0]                data_or;

`ifdef FIFO_ARB_LOCK_EN
  logic             lock_vld_q, lock_vld_d;
  logic [PTR_W-1:0] lock_idx_q, lock_idx_d;
`endif

  assign allow = ~full_q & ~flush & ~FIFO_reset;

  genvar g;
  generate
    for (g = 0; g < N_REQ; g++) begin : g_lane
      fifo_push_arbiter_lane #(
        .IDX(g), .PTR_W(PTR_W), .FIFO_width(FIFO_width)
      ) u_lane (
        .req_i   (req[g]),
        .allow_i (allow),
        .rr_ptr_i(rr_ptr_q),
        .gnt_i   (gnt[g]),
        .data_i  (req_data[g*FIFO_width +: FIFO_width]),
        .req_v_o (req_v[g]),
        .hi_o    (hi[g]),
        .data_o  (lane_data[g])
      );
    end
  endgenerate

  always_comb begin
    gnt_idx  = '0;
    gnt_any  = 1'b0;
    hi_found = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      if (!hi_found && hi[i]) begin
        hi_found = 1'b1;
        gnt_idx  = PTR_W'(i);
      end
    end
    gnt_any = hi_found;
    for (int i = 0; i < N_REQ; i++) begin
      if (!gnt_any && req_v[i]) begin
        gnt_any = 1'b1;
        gnt_idx = PTR_W'(i);
      end
    end
`ifdef FIFO_ARB_LOCK_EN
    // A locked owner keeps the port while it still requests with lock held.
    if (lock_vld_q && req_v[lock_idx_q] && lock[lock_idx_q]) begin
      gnt_any = 1'b1;
      gnt_idx = lock_idx_q;
    end
`endif
    gnt = gnt_any ? (N_REQ'(1) << gnt_idx) : '0;
  end

  always_comb begin
    data_or = '0;
    for (int i = 0; i < N_REQ; i++) data_or = data_or | lane_data[i];
  end

  assign push         = gnt_any;
  assign pop          = cons_pop & ~empty_q & ~flush & ~FIFO_reset;
  assign fifo_push    = push;
  assign fifo_pop     = pop;
  assign cons_ack     = pop;
  assign fifo_data_in = data_or;
  assign fifo_reset_n = ~(FIFO_reset | flush);
  assign level        = level_q;
  assign full         = full_q;
  assign empty        = empty_q;

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    // While locked this rewrites the same value, so the pointer stays put.
    if (gnt_any)
      rr_ptr_d = (gnt_idx == PTR_W'(N_REQ-1)) ? '0 : gnt_idx + 1'b1;
    level_d = level_q;
    case ({push, pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
    if (flush) level_d = '0;
    full_d  = (level_d == LVL_W'(FIFO_depth));
    empty_d = (level_d == '0);
`ifdef FIFO_ARB_LOCK_EN
    lock_vld_d = gnt_any & lock[gnt_idx];
    lock_idx_d = gnt_idx;
`endif
  end

  always_ff @(posedge clk) begin
    if (FIFO_reset) begin
      rr_ptr_q <= '0;
      level_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
`ifdef FIFO_ARB_LOCK_EN
      lock_vld_q <= 1'b0;
      lock_idx_q <= '0;
`endif
    end else begin
      rr_ptr_q <= rr_ptr_d;
      level_q  <= level_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
`ifdef FIFO_ARB_LOCK_EN
      lock_vld_q <= lock_vld_d;
      lock_idx_q <= lock_idx_d;
`endif
    end
  end
endmodule
